sdram_p2_arbiter: RTL and testbench

Round-robin arbiter that shares the SDRAM controller's second port (p2) between three independent requesters, e.g. fast-RAM CPU path, floppy/HDD DMA and the I/O controller loader. It sits directly in front of the controller's p2 interface. It converts the controller's toggle-style p2_ack into a one-cycle ack pulse per requester. It holds the selected request stable on p2 until that toggle arrives.

---
 rtl/sdram_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 46 ++++
 rtl/sdram_p2_arbiter.sv | 162 ++++++++++++++++
 tb/tb_sdram_p2_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared widths, FSM encoding and helpers for the SDRAM port-2 arbiter.
package sdram_arb_pkg;

    localparam int unsigned NREQ = 3;
    localparam int unsigned AW   = 22;
    localparam int unsigned DW   = 16;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    function automatic logic [NREQ-1:0] req_onehot(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational 3-way round-robin picker with optional strict priority for requester 0.
module rr_pick
    import sdram_arb_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
    input  logic [1:0]      last_i,
    input  logic            hipri0_i,
    output logic [1:0]      winner_o,
    output logic            any_o
);

    logic [1:0] first, second, third;

    always_comb begin
        // Search order starts just after the last winner.
        first  = 2'd0;
        second = 2'd1;
        third  = 2'd2;
        case (last_i)
            2'd0: begin
                first  = 2'd1;
                second = 2'd2;
                third  = 2'd0;
            end
            2'd1: begin
                first  = 2'd2;
                second = 2'd0;
                third  = 2'd1;
            end
            default: ;
        endcase

        any_o    = |req_i;
        winner_o = 2'd0;
        if (hipri0_i && req_i[0]) begin
            winner_o = 2'd0;
        end else if (req_i[first]) begin
            winner_o = first;
        end else if (req_i[second]) begin
            winner_o = second;
        end else if (req_i[third]) begin
            winner_o = third;
        end
    end

endmodule

// File: rtl/sdram_p2_arbiter.sv
// Shares SDRAM controller port 2 between three requesters; turns the toggle ack into
// one-cycle per-requester ack pulses and holds the granted request until the toggle.
module sdram_p2_arbiter
    import sdram_arb_pkg::*;
#(
    parameter bit HIPRI0 = 1'b0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ready_i,

    input  logic          r0_req_i,
    input  logic          r0_we_i,
    input  logic [AW-1:0] r0_addr_i,
    input  logic [1:0]    r0_ds_i,
    input  logic [DW-1:0] r0_din_i,
    output logic [DW-1:0] r0_dout_o,
    output logic          r0_ack_o,

    input  logic          r1_req_i,
    input  logic          r1_we_i,
    input  logic [AW-1:0] r1_addr_i,
    input  logic [1:0]    r1_ds_i,
    input  logic [DW-1:0] r1_din_i,
    output logic [DW-1:0] r1_dout_o,
    output logic          r1_ack_o,

    input  logic          r2_req_i,
    input  logic          r2_we_i,
    input  logic [AW-1:0] r2_addr_i,
    input  logic [1:0]    r2_ds_i,
    input  logic [DW-1:0] r2_din_i,
    output logic [DW-1:0] r2_dout_o,
    output logic          r2_ack_o,

    output logic          p2_cs_o,
    output logic          p2_we_o,
    output logic [AW-1:0] p2_addr_o,
    output logic [1:0]    p2_ds_o,
    output logic [DW-1:0] p2_din_o,
    input  logic [DW-1:0] p2_dout_i,
    input  logic          p2_ack_i
);

    state_e          state_q;
    logic [1:0]      last_q;
    logic [1:0]      cur_q;
    logic            ack_ref_q;
    logic [NREQ-1:0] ack_q;
    logic [DW-1:0]   dout0_q, dout1_q, dout2_q;

    logic            p2_cs_q;
    logic            p2_we_q;
    logic [AW-1:0]   p2_addr_q;
    logic [1:0]      p2_ds_q;
    logic [DW-1:0]   p2_din_q;

    logic [1:0]      winner;
    logic            any;
    logic            sel_we;
    logic [AW-1:0]   sel_addr;
    logic [1:0]      sel_ds;
    logic [DW-1:0]   sel_din;

    rr_pick u_pick (
        .req_i    ({r2_req_i, r1_req_i, r0_req_i}),
        .last_i   (last_q),
        .hipri0_i (HIPRI0),
        .winner_o (winner),
        .any_o    (any)
    );

    always_comb begin
        sel_we   = r0_we_i;
        sel_addr = r0_addr_i;
        sel_ds   = r0_ds_i;
        sel_din  = r0_din_i;
        case (winner)
            2'd1: begin
                sel_we   = r1_we_i;
                sel_addr = r1_addr_i;
                sel_ds   = r1_ds_i;
                sel_din  = r1_din_i;
            end
            2'd2: begin
                sel_we   = r2_we_i;
                sel_addr = r2_addr_i;
                sel_ds   = r2_ds_i;
                sel_din  = r2_din_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            last_q    <= 2'd2;
            cur_q     <= 2'd0;
            ack_ref_q <= 1'b0;
            ack_q     <= '0;
            dout0_q   <= '0;
            dout1_q   <= '0;
            dout2_q   <= '0;
            p2_cs_q   <= 1'b0;
            p2_we_q   <= 1'b0;
            p2_addr_q <= '0;
            p2_ds_q   <= '0;
            p2_din_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ready_i && any) begin
                        p2_cs_q   <= 1'b1;
                        p2_we_q   <= sel_we;
                        p2_addr_q <= sel_addr;
                        p2_ds_q   <= sel_ds;
                        p2_din_q  <= sel_din;
                        // Any toggle that happened before the grant is not ours.
                        ack_ref_q <= p2_ack_i;
                        last_q    <= winner;
                        cur_q     <= winner;
                        state_q   <= StBusy;
                    end
                end
                StBusy: begin
                    if (p2_ack_i != ack_ref_q) begin
                        p2_cs_q <= 1'b0;
                        ack_q   <= req_onehot(cur_q);
                        if (!p2_we_q) begin
                            case (cur_q)
                                2'd1:    dout1_q <= p2_dout_i;
                                2'd2:    dout2_q <= p2_dout_i;
                                default: dout0_q <= p2_dout_i;
                            endcase
                        end
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    ack_q   <= '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign p2_cs_o   = p2_cs_q;
    assign p2_we_o   = p2_we_q;
    assign p2_addr_o = p2_addr_q;
    assign p2_ds_o   = p2_ds_q;
    assign p2_din_o  = p2_din_q;

    assign r0_ack_o  = ack_q[0];
    assign r1_ack_o  = ack_q[1];
    assign r2_ack_o  = ack_q[2];
    assign r0_dout_o = dout0_q;
    assign r1_dout_o = dout1_q;
    assign r2_dout_o = dout2_q;

endmodule

// File: tb/tb_sdram_p2_arbiter.sv
// Directed bench for sdram_p2_arbiter: instance A is round-robin, instance B has HIPRI0=1.
module tb_sdram_p2_arbiter;

    localparam int LAT = 6;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ready = 1'b0;

    always #5 clk = ~clk;

    // Instance A (round-robin)
    logic [2:0]  req_a, we_a, ack_a;
    logic [21:0] addr_a [3];
    logic [1:0]  ds_a [3];
    logic [15:0] din_a [3];
    logic [15:0] dout_a [3];
    logic        cs_a, pwe_a;
    logic [21:0] paddr_a;
    logic [1:0]  pds_a;
    logic [15:0] pdin_a;
    logic [15:0] pdout_a = 16'h0;
    logic        pack_a = 1'b0;
    logic        auto_a = 1'b1;
    logic        kick_a = 1'b0;
    logic [15:0] mdata_a = 16'h0;
    int          cnt_a = 0;

    // Instance B (requester 0 strict priority)
    logic [2:0]  req_b, we_b, ack_b;
    logic [21:0] addr_b [3];
    logic [1:0]  ds_b [3];
    logic [15:0] din_b [3];
    logic [15:0] dout_b [3];
    logic        cs_b, pwe_b;
    logic [21:0] paddr_b;
    logic [1:0]  pds_b;
    logic [15:0] pdin_b;
    logic [15:0] pdout_b = 16'h0;
    logic        pack_b = 1'b0;
    int          cnt_b = 0;

    int n_vec = 0;
    int n_err = 0;

    sdram_p2_arbiter #(.HIPRI0(1'b0)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .ready_i(ready),
        .r0_req_i(req_a[0]), .r0_we_i(we_a[0]), .r0_addr_i(addr_a[0]), .r0_ds_i(ds_a[0]),
        .r0_din_i(din_a[0]), .r0_dout_o(dout_a[0]), .r0_ack_o(ack_a[0]),
        .r1_req_i(req_a[1]), .r1_we_i(we_a[1]), .r1_addr_i(addr_a[1]), .r1_ds_i(ds_a[1]),
        .r1_din_i(din_a[1]), .r1_dout_o(dout_a[1]), .r1_ack_o(ack_a[1]),
        .r2_req_i(req_a[2]), .r2_we_i(we_a[2]), .r2_addr_i(addr_a[2]), .r2_ds_i(ds_a[2]),
        .r2_din_i(din_a[2]), .r2_dout_o(dout_a[2]), .r2_ack_o(ack_a[2]),
        .p2_cs_o(cs_a), .p2_we_o(pwe_a), .p2_addr_o(paddr_a), .p2_ds_o(pds_a),
        .p2_din_o(pdin_a), .p2_dout_i(pdout_a), .p2_ack_i(pack_a)
    );

    sdram_p2_arbiter #(.HIPRI0(1'b1)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .ready_i(ready),
        .r0_req_i(req_b[0]), .r0_we_i(we_b[0]), .r0_addr_i(addr_b[0]), .r0_ds_i(ds_b[0]),
        .r0_din_i(din_b[0]), .r0_dout_o(dout_b[0]), .r0_ack_o(ack_b[0]),
        .r1_req_i(req_b[1]), .r1_we_i(we_b[1]), .r1_addr_i(addr_b[1]), .r1_ds_i(ds_b[1]),
        .r1_din_i(din_b[1]), .r1_dout_o(dout_b[1]), .r1_ack_o(ack_b[1]),
        .r2_req_i(req_b[2]), .r2_we_i(we_b[2]), .r2_addr_i(addr_b[2]), .r2_ds_i(ds_b[2]),
        .r2_din_i(din_b[2]), .r2_dout_o(dout_b[2]), .r2_ack_o(ack_b[2]),
        .p2_cs_o(cs_b), .p2_we_o(pwe_b), .p2_addr_o(paddr_b), .p2_ds_o(pds_b),
        .p2_din_o(pdin_b), .p2_dout_i(pdout_b), .p2_ack_i(pack_b)
    );

    // Controller models: toggle p2_ack LAT cycles after p2_cs rises.
    always @(posedge clk) begin
        if (kick_a) begin
            pack_a <= ~pack_a;
        end else if (auto_a && cs_a && cnt_a == LAT - 1) begin
            pack_a  <= ~pack_a;
            pdout_a <= mdata_a;
        end
        if (cs_a) cnt_a <= cnt_a + 1;
        else      cnt_a <= 0;
    end

    always @(posedge clk) begin
        if (cs_b && cnt_b == LAT - 1) begin
            pack_b  <= ~pack_b;
            pdout_b <= {paddr_b[7:0], pdin_b[7:0]} ^ {14'h0, pds_b} ^ {15'h0, pwe_b};
        end
        if (cs_b) cnt_b <= cnt_b + 1;
        else      cnt_b <= 0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits for the next ack pulse; idx=-1 on timeout, lows counts cycles with p2_cs low.
    task automatic wait_ack(input bit inst_b, output int idx, output int lows);
        logic [2:0] ack;
        logic       cs;
        idx  = -1;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            ack = inst_b ? ack_b : ack_a;
            cs  = inst_b ? cs_b : cs_a;
            if (!cs) lows++;
            if (ack != 3'b000) begin
                idx = (ack == 3'b001) ? 0 : (ack == 3'b010) ? 1 : (ack == 3'b100) ? 2 : 9;
                break;
            end
        end
    endtask

    initial begin
        int idx, lows;
        int exp_a [5] = '{0, 1, 2, 0, 1};

        req_a = '0; we_a = '0; req_b = '0; we_b = '0;
        for (int i = 0; i < 3; i++) begin
            addr_a[i] = '0; ds_a[i] = '0; din_a[i] = '0;
            addr_b[i] = '0; ds_b[i] = '0; din_b[i] = '0;
        end

        // Reset state
        repeat (3) tick();
        chk("rst_cs_we", {30'h0, cs_a, pwe_a}, 32'h0);
        chk("rst_addr", {10'h0, paddr_a}, 32'h0);
        chk("rst_ds_din", {14'h0, pds_a, pdin_a}, 32'h0);
        chk("rst_acks", {26'h0, ack_b, ack_a}, 32'h0);
        chk("rst_dout", {dout_a[0] | dout_a[1] | dout_a[2], dout_b[0] | dout_b[2]}, 32'h0);
        chk("rst_cs_b", {31'h0, cs_b}, 32'h0);
        reset_n = 1'b1;

        // Ready gating
        addr_a[0] = 22'h00100;
        mdata_a   = 16'h1111;
        req_a[0]  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("ready_gate_cs", {31'h0, cs_a}, 32'h0);
        end
        ready = 1'b1;
        tick();
        chk("ready_grant_cs", {31'h0, cs_a}, 32'h1);
        chk("ready_grant_addr", {10'h0, paddr_a}, 32'h00100);
        wait_ack(1'b0, idx, lows);
        chk("ready_ack_idx", idx, 0);
        chk("ready_dout0", {16'h0, dout_a[0]}, 32'h1111);
        req_a[0] = 1'b0;
        tick();
        chk("ready_ack_pulse", {29'h0, ack_a}, 32'h0);
        tick();

        // Read by r1
        addr_a[1] = 22'h12345;
        mdata_a   = 16'hBEEF;
        req_a[1]  = 1'b1;
        tick();
        chk("rd_cs", {31'h0, cs_a}, 32'h1);
        chk("rd_addr", {10'h0, paddr_a}, 32'h12345);
        chk("rd_we", {31'h0, pwe_a}, 32'h0);
        for (int i = 0; i < LAT; i++) begin
            tick();
            chk("rd_wait_cs_ack", {28'h0, cs_a, ack_a}, 32'h8);
        end
        tick();
        chk("rd_ack", {29'h0, ack_a}, 32'h2);
        chk("rd_dout1", {16'h0, dout_a[1]}, 32'hBEEF);
        chk("rd_cs_drop", {31'h0, cs_a}, 32'h0);
        req_a[1] = 1'b0;
        tick();
        chk("rd_ack_pulse", {29'h0, ack_a}, 32'h0);
        tick();

        // Write by r2; fields change after grant but p2 must hold
        addr_a[2] = 22'h2AAAA;
        we_a[2]   = 1'b1;
        ds_a[2]   = 2'b01;
        din_a[2]  = 16'hA55A;
        mdata_a   = 16'h7777;
        req_a[2]  = 1'b1;
        tick();
        chk("wr_we", {31'h0, pwe_a}, 32'h1);
        chk("wr_ds_din", {14'h0, pds_a, pdin_a}, {14'h0, 2'b01, 16'hA55A});
        din_a[2] = 16'h0000;
        ds_a[2]  = 2'b11;
        repeat (3) tick();
        chk("wr_hold", {13'h0, cs_a, pds_a, pdin_a}, {13'h0, 1'b1, 2'b01, 16'hA55A});
        wait_ack(1'b0, idx, lows);
        chk("wr_ack_idx", idx, 2);
        chk("wr_dout2_kept", {16'h0, dout_a[2]}, 32'h0);
        req_a[2] = 1'b0;
        we_a[2]  = 1'b0;
        tick();
        tick();

        // Round-robin with all three requesting
        mdata_a = 16'h1357;
        req_a   = 3'b111;
        for (int g = 0; g < 5; g++) begin
            wait_ack(1'b0, idx, lows);
            chk($sformatf("rr_grant%0d", g), idx, exp_a[g]);
            if (g > 0) chk($sformatf("rr_gap%0d", g), lows, 2);
        end
        req_a = 3'b000;
        tick();
        tick();

        // Strict priority on instance B
        req_b = 3'b101;
        for (int g = 0; g < 3; g++) begin
            wait_ack(1'b1, idx, lows);
            chk($sformatf("hp_grant%0d", g), idx, 0);
        end
        req_b[0] = 1'b0;
        wait_ack(1'b1, idx, lows);
        chk("hp_r2_after_drop", idx, 2);
        chk("hp_gap", lows, 2);
        req_b[2] = 1'b0;
        tick();
        tick();

        // Reset in the middle of a transaction, then a stale toggle
        auto_a    = 1'b0;
        addr_a[0] = 22'h03000;
        req_a[0]  = 1'b1;
        tick();
        chk("mrst_busy_cs", {31'h0, cs_a}, 32'h1);
        tick();
        tick();
        reset_n  = 1'b0;
        req_a[0] = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("mrst_cs_we", {30'h0, cs_a, pwe_a}, 32'h0);
        chk("mrst_addr", {10'h0, paddr_a}, 32'h0);
        chk("mrst_dout01", {dout_a[0], dout_a[1]}, 32'h0);
        kick_a = 1'b1;
        tick();
        kick_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mrst_stale", {28'h0, cs_a, ack_a}, 32'h0);
        end
        auto_a    = 1'b1;
        mdata_a   = 16'h5A5A;
        addr_a[2] = 22'h00ABC;
        req_a[2]  = 1'b1;
        tick();
        chk("mrst_regrant_addr", {10'h0, paddr_a}, 32'h00ABC);
        wait_ack(1'b0, idx, lows);
        chk("mrst_regrant_idx", idx, 2);
        chk("mrst_regrant_dout", {16'h0, dout_a[2]}, 32'h5A5A);
        req_a[2] = 1'b0;
        tick();
        chk("mrst_final_ack", {29'h0, ack_a}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
